pump_controller: RTL and testbench

//  Downstream consumer of the one-hot tank level code (0001 crit, 0010 low, 0100 mid, 1000 high, else error).

---
 rtl/pump_controller.sv | 169 ++++++++++++++++
 tb/tb_pump_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pump_controller.sv
// Tank fill pump controller: level filter, hysteresis FSM with
// min-off and max-fill timers, irrigation valve gating and alarm.
module pump_controller #(
    parameter int STABLE_CYCLES   = 4,
    parameter int ERR_CYCLES      = 8,
    parameter int MAX_FILL_CYCLES = 1024,
    parameter int MIN_OFF_CYCLES  = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] water_level_state,
    input  logic       enable,
    input  logic       irrigate_req,
    output logic       pump_on,
    output logic       valve_open,
    output logic       alarm,
    output logic [1:0] fault_code,
    output logic [2:0] ctrl_state,
    output logic [3:0] level_accepted
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_IDLE    = 3'd1,
        S_FILL    = 3'd2,
        S_HOLDOFF = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_LIM   = CNT_W'(ERR_CYCLES);
    localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(MAX_FILL_CYCLES);
    localparam logic [CNT_W-1:0] OFF_LIM   = CNT_W'(MIN_OFF_CYCLES);

    localparam logic [3:0] LVL_CRIT = 4'b0001;
    localparam logic [3:0] LVL_LOW  = 4'b0010;
    localparam logic [3:0] LVL_MID  = 4'b0100;
    localparam logic [3:0] LVL_HIGH = 4'b1000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       level_q, level_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] inv_q, inv_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       fault_q, fault_d;
    logic             pump_q, pump_d;
    logic             valve_q, valve_d;
    logic             alarm_q, alarm_d;
    logic             raw_valid;
    logic             sensor_err;
    logic [CNT_W-1:0] fill_inc;
    logic [CNT_W-1:0] hold_inc;

    // State register: every flop, including the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            cand_q  <= '0;
            level_q <= '0;
            match_q <= '0;
            inv_q   <= '0;
            fill_q  <= '0;
            hold_q  <= '0;
            fault_q <= '0;
            pump_q  <= 1'b0;
            valve_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            level_q <= level_d;
            match_q <= match_d;
            inv_q   <= inv_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
            fault_q <= fault_d;
            pump_q  <= pump_d;
            valve_q <= valve_d;
            alarm_q <= alarm_d;
        end
    end

    // Level filter: a valid code must repeat STABLE_CYCLES samples in a row
    always_comb begin
        raw_valid = (water_level_state == LVL_CRIT) ||
                    (water_level_state == LVL_LOW)  ||
                    (water_level_state == LVL_MID)  ||
                    (water_level_state == LVL_HIGH);
        cand_d  = water_level_state;
        match_d = (water_level_state == cand_q) ? sat_inc(match_q) : '0;
        inv_d   = raw_valid ? '0 : sat_inc(inv_q);
        level_d = level_q;
        if (raw_valid && (match_d >= STABLE_M1)) begin
            level_d = water_level_state;
        end
        sensor_err = (inv_d >= ERR_LIM);
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        fill_d   = '0;
        hold_d   = '0;
        fill_inc = sat_inc(fill_q);
        hold_inc = sat_inc(hold_q);
        if (!enable) begin
            state_d = S_OFF;
            fault_d = 2'b00;
        end else if (sensor_err &&
                     (state_q == S_IDLE || state_q == S_FILL ||
                      state_q == S_HOLDOFF)) begin
            state_d = S_FAULT;
            fault_d = 2'b01;
        end else begin
            unique case (state_q)
                S_OFF: state_d = S_IDLE;
                S_IDLE: begin
                    if (level_q == LVL_CRIT || level_q == LVL_LOW) begin
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    if (level_q == LVL_HIGH) begin
                        state_d = S_HOLDOFF;
                    end else if (fill_inc >= FILL_LIM) begin
                        state_d = S_FAULT;
                        fault_d = 2'b10;
                    end else begin
                        fill_d = fill_inc;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_inc >= OFF_LIM) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_OFF;
            endcase
        end
    end

    // Output logic, registered from the next state
    always_comb begin
        pump_d  = (state_d == S_FILL);
        alarm_d = (state_d == S_FAULT);
        valve_d = enable && irrigate_req && (state_d != S_FAULT) &&
                  (level_q == LVL_MID || level_q == LVL_HIGH);
    end

    assign pump_on        = pump_q;
    assign valve_open     = valve_q;
    assign alarm          = alarm_q;
    assign fault_code     = fault_q;
    assign ctrl_state     = state_q;
    assign level_accepted = level_q;

endmodule

// File: tb/tb_pump_controller.sv
// Self-checking bench for pump_controller: vector table, directed
// corner sequences and randomized stimulus against a reference model.
module tb_pump_controller;

    localparam int ST = 4;
    localparam int ER = 8;
    localparam int MF = 1024;
    localparam int MO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] water_level_state;
    logic       enable;
    logic       irrigate_req;
    logic       pump_on;
    logic       valve_open;
    logic       alarm;
    logic [1:0] fault_code;
    logic [2:0] ctrl_state;
    logic [3:0] level_accepted;

    pump_controller #(
        .STABLE_CYCLES(ST),
        .ERR_CYCLES(ER),
        .MAX_FILL_CYCLES(MF),
        .MIN_OFF_CYCLES(MO),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .water_level_state(water_level_state),
        .enable(enable),
        .irrigate_req(irrigate_req),
        .pump_on(pump_on),
        .valve_open(valve_open),
        .alarm(alarm),
        .fault_code(fault_code),
        .ctrl_state(ctrl_state),
        .level_accepted(level_accepted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state (states: 0 OFF 1 IDLE 2 FILL 3 HOLDOFF 4 FAULT)
    int         m_state, m_fc, m_level, m_pump, m_valve, m_alarm;
    int         m_inv, m_cyc, m_fill_start, m_hold_start;
    logic [3:0] hist[$];

    typedef struct {
        logic [3:0] raw;
        bit         en;
        bit         irr;
        int         st;
        int         pump;
        int         lvl;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit is_valid(input logic [3:0] r);
        return $countones(r) == 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_fc = 0; m_level = 0;
        m_pump = 0; m_valve = 0; m_alarm = 0;
        m_inv = 0; m_cyc = 0;
        m_fill_start = 0; m_hold_start = 0;
        hist.delete();
    endtask

    task automatic model_step(input logic [3:0] r, input bit en,
                              input bit irr);
        int old;
        int ns;
        bit acc;
        m_cyc++;
        hist.push_back(r);
        if (hist.size() > ST) void'(hist.pop_front());
        acc = is_valid(r) && (hist.size() == ST);
        foreach (hist[i]) if (hist[i] != r) acc = 0;
        m_inv = is_valid(r) ? 0 : m_inv + 1;
        old = m_state;
        ns = old;
        if (!en) begin
            ns = 0;
            m_fc = 0;
        end else if (m_inv >= ER && old >= 1 && old <= 3) begin
            ns = 4;
            m_fc = 1;
        end else begin
            case (old)
                0: ns = 1;
                1: if (m_level == 1 || m_level == 2) ns = 2;
                2: begin
                    if (m_level == 8) ns = 3;
                    else if (m_cyc - m_fill_start >= MF) begin
                        ns = 4;
                        m_fc = 2;
                    end
                end
                3: if (m_cyc - m_hold_start >= MO) ns = 1;
                default: ns = old;
            endcase
        end
        if (ns == 2 && old != 2) m_fill_start = m_cyc;
        if (ns == 3 && old != 3) m_hold_start = m_cyc;
        m_valve = (en && irr && ns != 4 &&
                   (m_level == 4 || m_level == 8)) ? 1 : 0;
        m_pump  = (ns == 2) ? 1 : 0;
        m_alarm = (ns == 4) ? 1 : 0;
        if (acc) m_level = int'(r);
        m_state = ns;
    endtask

    task automatic check_model();
        chk("m_state", int'(ctrl_state), m_state);
        chk("m_pump", int'(pump_on), m_pump);
        chk("m_valve", int'(valve_open), m_valve);
        chk("m_alarm", int'(alarm), m_alarm);
        chk("m_fault", int'(fault_code), m_fc);
        chk("m_level", int'(level_accepted), m_level);
    endtask

    task automatic cycle(input logic [3:0] r, input bit en, input bit irr);
        water_level_state = r;
        enable = en;
        irrigate_req = irr;
        @(posedge clk);
        model_step(r, en, irr);
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input logic [3:0] r, input bit en, input bit irr,
                       input int n);
        for (int i = 0; i < n; i++) cycle(r, en, irr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        water_level_state = 4'b0000;
        enable = 1'b0;
        irrigate_req = 1'b0;
        model_reset();
        #2;
        chk("rst_state", int'(ctrl_state), 0);
        chk("rst_pump", int'(pump_on), 0);
        chk("rst_valve", int'(valve_open), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_fault", int'(fault_code), 0);
        chk("rst_level", int'(level_accepted), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] pick[7];

    initial begin
        tbl[0] = '{4'b0010, 1'b1, 1'b0, 1, 0, 0};
        tbl[1] = '{4'b0010, 1'b1, 1'b0, 1, 0, 0};
        tbl[2] = '{4'b0010, 1'b1, 1'b0, 1, 0, 0};
        tbl[3] = '{4'b0010, 1'b1, 1'b0, 1, 0, 2};
        tbl[4] = '{4'b0010, 1'b1, 1'b0, 2, 1, 2};
        pick[0] = 4'b0001; pick[1] = 4'b0010; pick[2] = 4'b0100;
        pick[3] = 4'b1000; pick[4] = 4'b0000; pick[5] = 4'b0110;
        pick[6] = 4'b1000;

        reset = 1'b1;
        water_level_state = '0;
        enable = 1'b0;
        irrigate_req = 1'b0;
        model_reset();
        do_reset();

        // Low level accepted on the 4th edge, fill starts on the next
        foreach (tbl[i]) begin
            cycle(tbl[i].raw, tbl[i].en, tbl[i].irr);
            chk("tbl_state", int'(ctrl_state), tbl[i].st);
            chk("tbl_pump", int'(pump_on), tbl[i].pump);
            chk("tbl_level", int'(level_accepted), tbl[i].lvl);
        end

        // High ends fill, holdoff lasts MO cycles, then refill
        run(4'b1000, 1, 0, 4);
        chk("t2_fill_until_high", int'(ctrl_state), 2);
        cycle(4'b1000, 1, 0);
        chk("t2_holdoff", int'(ctrl_state), 3);
        chk("t2_pump_off", int'(pump_on), 0);
        run(4'b0001, 1, 0, MO - 1);
        chk("t2_hold_kept", int'(ctrl_state), 3);
        cycle(4'b0001, 1, 0);
        chk("t2_idle", int'(ctrl_state), 1);
        cycle(4'b0001, 1, 0);
        chk("t2_refill", int'(ctrl_state), 2);
        chk("t2_refill_pump", int'(pump_on), 1);

        // Fill timeout
        run(4'b0001, 1, 0, MF - 1);
        chk("t3_pre_timeout", int'(ctrl_state), 2);
        cycle(4'b0001, 1, 0);
        chk("t3_timeout", int'(ctrl_state), 4);
        chk("t3_code", int'(fault_code), 2);
        chk("t3_alarm", int'(alarm), 1);
        chk("t3_pump", int'(pump_on), 0);
        cycle(4'b0001, 0, 0);
        chk("t3_off", int'(ctrl_state), 0);
        chk("t3_code_clr", int'(fault_code), 0);

        // Sensor fault threshold
        do_reset();
        run(4'b0100, 1, 0, 5);
        run(4'b0000, 1, 0, 7);
        run(4'b0100, 1, 0, 1);
        chk("t4_no_fault", int'(ctrl_state), 1);
        chk("t4_no_code", int'(fault_code), 0);
        run(4'b0110, 1, 0, ER - 1);
        chk("t4_pre_fault", int'(ctrl_state), 1);
        cycle(4'b0110, 1, 0);
        chk("t4_fault", int'(ctrl_state), 4);
        chk("t4_code", int'(fault_code), 1);
        chk("t4_level_kept", int'(level_accepted), 4);

        // Irrigation valve gating
        do_reset();
        run(4'b0100, 1, 1, 4);
        chk("t5_level_mid", int'(level_accepted), 4);
        cycle(4'b0100, 1, 1);
        chk("t5_valve_open", int'(valve_open), 1);
        run(4'b0010, 1, 1, 4);
        chk("t5_level_low", int'(level_accepted), 2);
        chk("t5_valve_lag", int'(valve_open), 1);
        cycle(4'b0010, 1, 1);
        chk("t5_valve_shut", int'(valve_open), 0);
        chk("t5_pump_start", int'(pump_on), 1);

        // Glitching input never accepted; async reset mid-fill
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle((i % 2) ? 4'b0100 : 4'b0010, 1, 0);
        end
        chk("t6_no_accept", int'(level_accepted), 0);
        run(4'b0001, 1, 0, 5);
        chk("t6_fill", int'(pump_on), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_async_pump", int'(pump_on), 0);
        chk("t6_async_state", int'(ctrl_state), 0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized run against the model
        begin
            logic [3:0] r;
            int hold;
            bit en;
            bit irr;
            r = 4'b0010;
            hold = 0;
            en = 1;
            irr = 0;
            for (int c = 0; c < 3000; c++) begin
                if (hold == 0) begin
                    r = pick[$urandom_range(0, 6)];
                    hold = $urandom_range(1, 12);
                    irr = $urandom_range(0, 1) == 1;
                    en = $urandom_range(0, 29) != 0;
                end
                hold--;
                if ($urandom_range(0, 799) == 0) do_reset();
                else cycle(r, en, irr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
